// File: rtl/fir_filter_mac.sv
// fir_filter_mac: time-multiplexed single-MAC FIR filter with valid/ready sample and result handshakes.
// Define FIR_SAT_EN to clamp the output instead of wrapping it.
module fir_filter_mac #(
   parameter int NUM_TAPS  = 8,
   parameter int DATA_W    = 8,
   parameter int COEF_W    = 16,
   parameter int OUT_W     = 16,
   parameter int OUT_SHIFT = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [DATA_W-1:0]      x_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [OUT_W-1:0]       y_out,
   input  logic                          coef_we,
   input  logic [$clog2(NUM_TAPS)-1:0]   coef_addr,
   input  logic signed [COEF_W-1:0]      coef_wdata
);
   localparam int AW = $clog2(NUM_TAPS);
   localparam int ACC_W = DATA_W + COEF_W + AW;
   localparam logic [1:0] IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2;
   logic [1:0] state_q, state_d;
   logic signed [DATA_W-1:0] x_q [NUM_TAPS];
   logic signed [DATA_W-1:0] x_d [NUM_TAPS];
   logic signed [COEF_W-1:0] coef_q [NUM_TAPS];
   logic signed [COEF_W-1:0] coef_d [NUM_TAPS];
   logic signed [ACC_W-1:0] acc_q, acc_d, prod;
   logic [AW-1:0] idx_q, idx_d;
   logic last_q, last_d;
   logic signed [OUT_W-1:0] y_q, y_d, sized;
   assign prod = ACC_W'(coef_q[idx_q]) * ACC_W'(x_q[idx_q]);
`ifdef FIR_SAT_EN
   logic signed [ACC_W-1:0] shifted;
   logic ovf;
   assign shifted = acc_q >>> OUT_SHIFT;
   assign ovf = ~&shifted[ACC_W-1:OUT_W-1] & |shifted[ACC_W-1:OUT_W-1];
   assign sized = ovf ? {shifted[ACC_W-1], {(OUT_W-1){~shifted[ACC_W-1]}}} : shifted[OUT_W-1:0];
`else
   assign sized = OUT_W'(acc_q >>> OUT_SHIFT);
`endif
   assign in_ready = state_q == IDLE;
   assign out_valid = state_q == OUT;
   assign y_out = y_q;
   // last_q adds the cycle that registers the completed sum, giving NUM_TAPS+1 latency
   always_comb begin
      state_d = state_q;
      x_d = x_q;
      coef_d = coef_q;
      acc_d = acc_q;
      idx_d = idx_q;
      last_d = last_q;
      y_d = y_q;
      if (state_q == IDLE && coef_we && int'(coef_addr) < NUM_TAPS) coef_d[coef_addr] = coef_wdata;
      if (state_q == IDLE && in_valid) begin
         for (int k = 1; k < NUM_TAPS; k++) x_d[k] = x_q[k-1];
         x_d[0] = x_in;
         acc_d = '0;
         idx_d = '0;
         last_d = 1'b0;
         state_d = MAC;
      end
      if (state_q == MAC && last_q) begin
         y_d = sized;
         state_d = OUT;
      end
      if (state_q == MAC && !last_q) begin
         acc_d = acc_q + prod;
         last_d = idx_q == AW'(NUM_TAPS - 1);
         idx_d = last_d ? idx_q : idx_q + 1'b1;
      end
      if (state_q == OUT && out_ready) state_d = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         for (int k = 0; k < NUM_TAPS; k++) begin
            x_q[k] <= '0;
            coef_q[k] <= (k == 0) ? COEF_W'(1) : '0;
         end
         acc_q <= '0;
         idx_q <= '0;
         last_q <= 1'b0;
         y_q <= '0;
      end else begin
         state_q <= state_d;
         x_q <= x_d;
         coef_q <= coef_d;
         acc_q <= acc_d;
         idx_q <= idx_d;
         last_q <= last_d;
         y_q <= y_d;
      end
   end
endmodule

// File: doc/fir_filter_mac.md
FIR_FILTER_MAC -- requirements
Module: fir_filter_mac

Interface
REQ-001 Parameter NUM_TAPS, default 8, number of filter taps (2..64).
REQ-002 Parameter DATA_W, default 8, input sample width, signed two's complement.
REQ-003 Parameter COEF_W, default 16, coefficient width, signed two's complement.
REQ-004 Parameter OUT_W, default 16, output width, signed.
REQ-005 Parameter OUT_SHIFT, default 0, arithmetic right shift applied to the accumulator before output sizing.
REQ-006 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Ports in_valid (input, 1), in_ready (output, 1), x_in (input, DATA_W): sample input handshake.
REQ-009 Ports out_valid (output, 1), out_ready (input, 1), y_out (output, OUT_W): result output handshake.
REQ-010 Ports coef_we (input, 1), coef_addr (input, clog2(NUM_TAPS)), coef_wdata (input, COEF_W): coefficient write port.

Function
REQ-011 Datapath is one time-multiplexed multiply-accumulate unit; y[n] = sum over k = 0..NUM_TAPS-1 of coef[k]*x[n-k].
REQ-012 Accumulator width ACC_W = DATA_W + COEF_W + clog2(NUM_TAPS); no internal overflow is possible.
REQ-013 FSM states: IDLE, MAC, OUT; in_ready = 1 only in IDLE; out_valid = 1 only in OUT.
REQ-014 IDLE: on in_valid & in_ready, shift delay line (x[k] <= x[k-1], x[0] <= x_in), clear accumulator, set tap index to 0, go to MAC.
REQ-015 MAC: each cycle acc += coef[idx]*x[idx], idx++; after idx = NUM_TAPS-1 is accumulated, register the sized result into y_out and go to OUT.
REQ-016 OUT: y_out and out_valid held stable while out_ready = 0; on out_ready = 1 go to IDLE.
REQ-017 Latency: out_valid rises NUM_TAPS+1 cycles after the accepting edge; minimum sample period is NUM_TAPS+2 cycles.
REQ-018 Output sizing: acc >>> OUT_SHIFT, then reduce to OUT_W per REQ-026/REQ-027.
REQ-019 Coefficient writes take effect only in IDLE and only when coef_addr < NUM_TAPS; all other writes are silently dropped.
REQ-020 A coef_we coinciding with sample acceptance in IDLE is applied first and is used by that sample's MAC pass.
REQ-021 The delay line shifts only on accepted samples, never on backpressure or coefficient writes.

Reset
REQ-022 On rst_n low: FSM = IDLE, all delay-line entries = 0, accumulator = 0, tap index = 0, y_out = 0, out_valid = 0.
REQ-023 On rst_n low: coef[0] = 1, all other coefficients = 0 (identity filter).
REQ-024 Reset asserted mid-MAC or in OUT aborts the operation; no partial result is ever presented.
REQ-025 in_ready reads 1 during reset and on the first edge after rst_n release.

Configuration
REQ-026 With FIR_SAT_EN defined: the shifted accumulator is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-027 Without FIR_SAT_EN: the shifted accumulator is truncated to its low OUT_W bits (two's-complement wrap).

Verification (NUM_TAPS=4, DATA_W=8, COEF_W=16, OUT_W=16, OUT_SHIFT=0)
REQ-028 Impulse: load coefficients 1,2,3,4; feed 1,0,0,0,0 -> outputs 1,2,3,4,0.
REQ-029 Reset defaults: no coefficient writes; feed -5,7 -> outputs -5,7 (identity filter).
REQ-030 Overflow: all coefficients 32767; feed 127 five times -> 4th and 5th outputs are 0x7FFF with FIR_SAT_EN and 0xFE04 without it.
REQ-031 Backpressure: hold out_ready = 0 for 10 cycles in OUT -> y_out and out_valid stable, in_ready = 0, x_in ignored, no sample lost.
REQ-032 Coefficient write during MAC to address 1 -> current result is unchanged and a later IDLE read-back via impulse still shows the old value.
REQ-033 Reset: assert rst_n = 0 two cycles into MAC -> out_valid = 0, y_out = 0; next impulse after release -> output 1.
